// File: rtl/dct_sched.sv
// Round-robin scheduler sharing one 2D DCT/IDCT engine between N_REQ block producers.
// Grants a requester for a burst of blocks and paces engine start pulses one BLOCK_CYCLES window apart.
`timescale 1ns/1ps
module dct_sched #(
    parameter int N_REQ        = 4,
    parameter int ID_W         = 2,
    parameter int BLOCK_CYCLES = 80,
    parameter int MAX_BURST    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   nblk,
    output logic [N_REQ-1:0]     gnt,
    output logic                 dct_load,
    output logic                 blk_start,
    output logic                 blk_done,
    output logic [ID_W-1:0]      cur_id,
    output logic                 burst_end,
    output logic                 busy,
    output logic [1:0]           dbg_state
);
    // Handshake: req is a level; a requester owns the engine while its gnt bit is high,
    // and gnt is only removed after the burst's final blk_done cycle.
    localparam int OCC_W = (BLOCK_CYCLES > 1) ? $clog2(BLOCK_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [7:0]        rem_q, rem_d;
    logic [7:0]        bcnt_q, bcnt_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic              hi_found;
    logic [ID_W-1:0]   hi_id, lo_id, win_id;
    logic [7:0]        hi_nblk, lo_nblk, win_nblk;
    logic              last_occ, cont;

    // Winner is the lowest set index above ptr, else the lowest set index overall.
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        hi_nblk  = '0;
        lo_nblk  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && (ID_W'(i) > ptr_q)) begin
                hi_found = 1'b1;
                hi_id    = ID_W'(i);
                hi_nblk  = nblk[8*i +: 8];
            end
            if (req[i]) begin
                lo_id   = ID_W'(i);
                lo_nblk = nblk[8*i +: 8];
            end
        end
        win_id   = hi_found ? hi_id : lo_id;
        win_nblk = hi_found ? hi_nblk : lo_nblk;
    end

    assign last_occ = (state_q == S_RUN) && (occ_q == OCC_W'(BLOCK_CYCLES - 1));
    assign cont     = (rem_q > 8'd1) && (bcnt_q < 8'(MAX_BURST)) && req[id_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        rem_d   = rem_q;
        bcnt_d  = bcnt_q;
        occ_d   = occ_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    id_d    = win_id;
                    ptr_d   = win_id;
                    rem_d   = (win_nblk == 8'd0) ? 8'd1 : win_nblk;
                    bcnt_d  = 8'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                occ_d   = '0;
                bcnt_d  = bcnt_q + 8'd1;
                state_d = S_RUN;
            end
            S_RUN: begin
                occ_d = occ_q + OCC_W'(1);
                if (last_occ) begin
                    rem_d   = rem_q - 8'd1;
                    state_d = cont ? S_START : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            rem_q   <= '0;
            bcnt_q  <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            rem_q   <= rem_d;
            bcnt_q  <= bcnt_d;
            occ_q   <= occ_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign gnt       = busy ? (N_REQ'(1) << id_q) : '0;
    assign cur_id    = id_q;
    assign dct_load  = (state_q == S_START);
    assign blk_start = (state_q == S_START);
    assign blk_done  = last_occ;
    assign burst_end = last_occ && !cont;
    assign dbg_state = state_q;
endmodule

// File: doc/dct_sched.md
# dct_sched

Round-robin scheduler that shares the single 2D DCT/IDCT engine between up to N_REQ block producers (e.g. luma, Cb, Cr, inverse path). It arbitrates requests, holds a one-hot grant for a burst of back-to-back blocks, and issues the one-cycle `load` start pulse to the engine's sequencing FSM. It spaces starts so that each block occupies the engine for a full BLOCK_CYCLES window. The block sits between the residual/coefficient producers and the DCT engine control input, and carries no datapath.

## Interface
- N_REQ, 4: number of requesters (2..8)
- ID_W, 2: width of requester index, ceil(log2(N_REQ))
- BLOCK_CYCLES, 80: engine occupancy per block, counted from the cycle after `dct_load`
- MAX_BURST, 16: maximum blocks per grant before forced re-arbitration (1..255)

Ports:
- clk  in  1  clock, all flops on rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-requester request level
- nblk  in  8*N_REQ  blocks wanted; requester i at bits [8i+7:8i]; 0 is treated as 1
- gnt  out  N_REQ  one-hot grant, held for the whole burst
- dct_load  out  1  one-cycle start pulse to the DCT engine
- blk_start  out  1  pulse coincident with `dct_load`
- blk_done  out  1  pulse in last occupancy cycle of a block
- cur_id  out  ID_W  index of the granted requester, valid while `busy`
- burst_end  out  1  pulse coincident with the final `blk_done` of a burst
- busy  out  1  high from grant to the end of burst

## Operation
- States: IDLE, START, RUN. All outputs are Moore-decoded from registered state and counters.
- IDLE: if |req, select the winner by round-robin. The search starts at `ptr+1` mod N_REQ and the first set bit wins. On that edge:
  - latch cur_id
  - latch `rem = max(nblk[cur_id],1)`
  - clear `bcnt` (blocks issued this burst)
  - set `ptr = cur_id`
  - set gnt one-hot
  - go to START
- START (one cycle): `dct_load=1` and `blk_start=1`. On the edge: `occ=0`, `bcnt++`, go to RUN.
- RUN: `occ` increments every cycle. When `occ == BLOCK_CYCLES-1`, `blk_done=1` and `rem` decrements on that edge. Next state on that edge:
  - START if `rem>1`, `bcnt<MAX_BURST` and `req[cur_id]` is still high
  - otherwise IDLE, with gnt cleared and `burst_end=1` in this same final cycle
- Requester dropping `req` mid-block does not abort the block; the burst ends at that block's `blk_done`.
- Preempted requester (MAX_BURST reached) keeps `req` high and must update `nblk` to its remaining count before its next grant. It counts its own `blk_done` pulses while its `gnt` bit is high.
- `nblk` is sampled only at arbitration; changes during a burst are ignored.
- `req` bits of non-granted requesters are ignored until the next IDLE.
- Widths: `rem` 8 bits, `bcnt` 8 bits, `occ` ceil(log2(BLOCK_CYCLES)) bits. None of these wraps within legal parameters.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, gnt=0, dct_load=0, blk_start=0, blk_done=0, burst_end=0, busy=0, cur_id=0, ptr=N_REQ-1 (requester 0 first), rem=0, bcnt=0, occ=0.
- Reset release is synchronous to clk. Reset asserted mid-burst drops gnt and busy immediately. The engine is reset by the same rst.
- Latency: `req` high in IDLE at edge k gives gnt/busy high at k+1 and `dct_load` in cycle k+1.
- `blk_done` occurs BLOCK_CYCLES cycles after `dct_load`.
- Back-to-back blocks in a burst: `dct_load` period = BLOCK_CYCLES+1 (81 by default).
- Burst end to next grant: IDLE lasts ≥1 cycle. The next `dct_load` comes 2 cycles after `burst_end`.
- Simultaneous requests: round-robin only; no fixed priority except the reset pointer.

## Test plan
- Single request: req=4'b0001, nblk0=3 → dct_load at cycles 1, 82, 163; blk_done at 81, 162, 243; burst_end at 243; gnt=0001 throughout; busy falls at 244.
- Contention: req=4'b1011 from reset, nblk=1 each → grant order 0, 1, 3, then 0 again; `dct_load` 2 cycles after each burst_end.
- Preemption: MAX_BURST=2, req0 with nblk0=5, req2 pending → exactly 2 blocks for 0, then 2 blocks for 2, then 0 resumes (after updating nblk0=3).
- Early drop: nblk0=4, req0 deasserted at cycle 100 (during block 2) → block 2 completes, blk_done and burst_end at cycle 162, no third dct_load.
- nblk=0: req1 with nblk1=0 → exactly one block, burst_end with its blk_done.
- Async reset at cycle 50 mid-RUN: all outputs 0 immediately, no blk_done. After release with req2 held → gnt=0100 one cycle later and pointer order restarts from requester 0.
